// File: rtl/seqdet_multi.sv
// Multi-channel serial pattern detector with per-channel care masks and overlap control.
// Define SEQDET_MULTI_CNT_EN to build the per-channel saturating hit counters.
module seqdet_multi #(
  parameter int W  = 6,
  parameter int N  = 2,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            x,
  input  logic            x_valid,
  input  logic [N*W-1:0]  match,
  input  logic [N*W-1:0]  care,
  input  logic            overlap,
  input  logic            clr_cnt,
  output logic [W-1:0]    q,
  output logic [N-1:0]    z,
  output logic            z_any,
  output logic            filled,
  output logic [N*CW-1:0] hit_cnt
);

  localparam int FW = $clog2(W + 1);
  localparam int GW = $clog2(W);
  localparam logic [FW-1:0] FILL_MAX   = FW'(W);
  localparam logic [FW-1:0] FILL_LAST  = FW'(W - 1);
  localparam logic [GW-1:0] GUARD_INIT = GW'(W - 1);

  logic [FW-1:0] fill_cnt;
  logic [GW-1:0] guard [N];
  logic [W-1:0]  nq;
  logic          full_next;
  logic [N-1:0]  hit;

  assign nq        = {q[W-2:0], x};
  assign full_next = (fill_cnt >= FILL_LAST);
  assign filled    = (fill_cnt == FILL_MAX);
  assign z_any     = |z;

  // hit evaluation against the candidate window that this edge would produce
  always_comb begin
    hit = '0;
    for (int i = 0; i < N; i++) begin
      if (x_valid && full_next &&
          (((nq ^ match[i*W +: W]) & care[i*W +: W]) == '0) &&
          (overlap || (guard[i] == '0)))
        hit[i] = 1'b1;
    end
  end

  // p0: shift register, fill count, pulses and non-overlap guards
  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      fill_cnt <= '0;
      z        <= '0;
      for (int i = 0; i < N; i++) guard[i] <= '0;
    end else begin
      z <= hit;
      if (x_valid) begin
        q <= nq;
        if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + 1'b1;
        for (int i = 0; i < N; i++) begin
          // a hit in overlapping mode leaves the channel armed
          if (hit[i])              guard[i] <= overlap ? '0 : GUARD_INIT;
          else if (guard[i] != '0) guard[i] <= guard[i] - 1'b1;
        end
      end
    end
  end

`ifdef SEQDET_MULTI_CNT_EN
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CW-1:0] cnt [N];

  // p0: hit counters, clear takes precedence over a same-edge hit
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst || clr_cnt) cnt[i] <= '0;
      else if (hit[i])    cnt[i] <= sat_inc(cnt[i]);
    end
  end

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < N; i++) hit_cnt[i*CW +: CW] = cnt[i];
  end
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign hit_cnt    = '0;
`endif

endmodule

// File: tb/tb_seqdet_multi.sv
// Directed bench for seqdet_multi: queue-based reference model checked every cycle plus literal spot checks.
module tb_seqdet_multi;

  localparam int W  = 6;
  localparam int N  = 2;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;
`ifdef SEQDET_MULTI_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            x = 1'b0;
  logic            x_valid = 1'b0;
  logic [N*W-1:0]  match = '0;
  logic [N*W-1:0]  care = '1;
  logic            overlap = 1'b1;
  logic            clr_cnt = 1'b0;
  logic [W-1:0]    q;
  logic [N-1:0]    z;
  logic            z_any;
  logic            filled;
  logic [N*CW-1:0] hit_cnt;

  int checks = 0;
  int fails  = 0;

  seqdet_multi #(.W(W), .N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .match(match), .care(care),
    .overlap(overlap), .clr_cnt(clr_cnt), .q(q), .z(z), .z_any(z_any),
    .filled(filled), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: history of accepted bits, count of accepted bits since
  // reset, index of the last non-overlapping hit per channel, hit totals.
  int          hist[$];
  int          nacc = 0;
  int          last_hit [N];
  logic [N-1:0] ez = '0;
  int          ecnt [N];

  function automatic bit chan_matches(int ch);
    for (int j = 0; j < W; j++)
      if (care[ch*W + j] && (hist[hist.size()-1-j] != int'(match[ch*W + j])))
        return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    if (rst) begin
      hist.delete();
      nacc = 0;
      ez = '0;
      for (int i = 0; i < N; i++) begin last_hit[i] = -1000; ecnt[i] = 0; end
    end else begin
      ez = '0;
      if (x_valid) begin
        hist.push_back(int'(x));
        if (hist.size() > W) void'(hist.pop_front());
        nacc++;
        if (nacc >= W) begin
          for (int i = 0; i < N; i++) begin
            if (chan_matches(i) && (overlap || (nacc - last_hit[i] >= W))) begin
              ez[i] = 1'b1;
              last_hit[i] = overlap ? -1000 : nacc;
              if (ecnt[i] < CMAX) ecnt[i]++;
            end
          end
        end
      end
      if (clr_cnt) for (int i = 0; i < N; i++) ecnt[i] = 0;
    end
  endtask

  task automatic model_compare();
    logic [W-1:0]    eq;
    logic [N*CW-1:0] ec;
    eq = '0;
    for (int j = 0; j < hist.size(); j++) eq[j] = hist[hist.size()-1-j][0];
    ec = '0;
    if (CNT_EN) for (int i = 0; i < N; i++) ec[i*CW +: CW] = CW'(ecnt[i]);
    check("model_q", 64'(q), 64'(eq));
    check("model_z", 64'(z), 64'(ez));
    check("model_z_any", 64'(z_any), 64'(|ez));
    check("model_filled", 64'(filled), 64'(nacc >= W));
    check("model_hit_cnt", 64'(hit_cnt), 64'(ec));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin last_hit[i] = -1000; ecnt[i] = 0; end
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      model_compare();
    end
  end

  function automatic logic [63:0] cnt_exp(int v);
    return CNT_EN ? 64'(v) : 64'd0;
  endfunction

  task automatic bitv(input logic b);
    x = b; x_valid = 1'b1;
    @(posedge clk); #1;
    x_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) bitv(v[k]);
  endtask

  task automatic idle(input int n);
    x_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; x_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic cfg(input logic [W-1:0] m0, input logic [W-1:0] c0,
                     input logic [W-1:0] m1, input logic [W-1:0] c1, input logic ov);
    match = {m1, m0}; care = {c1, c0}; overlap = ov;
  endtask

  initial begin
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    check("reset_q", 64'(q), 64'd0);
    check("reset_z", 64'(z), 64'd0);
    check("reset_filled", 64'(filled), 64'd0);
    check("reset_hit_cnt", 64'(hit_cnt), 64'd0);

    // overlapping detection of 110011 in 1100110011
    cfg(6'b110011, 6'b111111, 6'b000000, 6'b111111, 1'b1);
    send_bits(32'b110011, 6);
    check("ovl_z_bit6", 64'(z), 64'b01);
    send_bits(32'b0011, 4);
    check("ovl_z_bit10", 64'(z), 64'b01);
    check("ovl_q_bit10", 64'(q), 64'b110011);
    check("ovl_cnt", 64'(hit_cnt[CW-1:0]), cnt_exp(2));

    // non-overlapping: bit 10 suppressed, bit 16 hits
    do_reset();
    cfg(6'b110011, 6'b111111, 6'b000000, 6'b111111, 1'b0);
    send_bits(32'b110011, 6);
    check("novl_z_bit6", 64'(z), 64'b01);
    send_bits(32'b0011, 4);
    check("novl_z_bit10", 64'(z), 64'b00);
    send_bits(32'b110011, 6);
    check("novl_z_bit16", 64'(z), 64'b01);

    // fill boundary with an all-zero pattern
    do_reset();
    cfg(6'b000000, 6'b111111, 6'b111111, 6'b111111, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      bitv(1'b0);
      check("fill_early_z", 64'(z), 64'd0);
      check("fill_early_filled", 64'(filled), 64'd0);
    end
    bitv(1'b0);
    check("fill_bit6_filled", 64'(filled), 64'd1);
    check("fill_bit6_z", 64'(z), 64'b01);
    bitv(1'b0);
    check("fill_bit7_z", 64'(z), 64'b01);

    // two channels with partial care masks both hit
    do_reset();
    cfg(6'b110000, 6'b111100, 6'b000001, 6'b000011, 1'b1);
    send_bits(32'b110001, 6);
    check("dual_z", 64'(z), 64'b11);
    check("dual_z_any", 64'(z_any), 64'd1);

    // stall between bits 3 and 4
    do_reset();
    cfg(6'b110011, 6'b111111, 6'b000000, 6'b111111, 1'b1);
    send_bits(32'b110, 3);
    x = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle(1);
      check("stall_q", 64'(q), 64'b000110);
      check("stall_z", 64'(z), 64'd0);
    end
    send_bits(32'b011, 3);
    check("stall_z_bit6", 64'(z), 64'b01);
    idle(1);
    check("stall_z_after", 64'(z), 64'd0);
    idle(1);

    // saturation, clear-wins, reset mid-stream
    do_reset();
    cfg(6'b000000, 6'b000000, 6'b111111, 6'b111111, 1'b1);
    send_bits(32'b0, 10);
    check("sat_cnt", 64'(hit_cnt[CW-1:0]), cnt_exp(3));
    clr_cnt = 1'b1;
    bitv(1'b0);
    clr_cnt = 1'b0;
    check("clr_z", 64'(z), 64'b01);
    check("clr_cnt", 64'(hit_cnt[CW-1:0]), 64'd0);
    bitv(1'b1);
    check("clr_recount", 64'(hit_cnt[CW-1:0]), cnt_exp(1));
    do_reset();
    cfg(6'b110011, 6'b111111, 6'b000000, 6'b111111, 1'b1);
    send_bits(32'b1100, 4);
    do_reset();
    send_bits(32'b11, 2);
    check("rst_mid_z", 64'(z), 64'd0);
    check("rst_mid_filled", 64'(filled), 64'd0);
    check("rst_mid_q", 64'(q), 64'b000011);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/seqdet_multi.md
SEQDET_MULTI -- requirements
Module: seqdet_multi

Interface
REQ-001 Parameter W, default 6, pattern width in bits; legal range 2..32.
REQ-002 Parameter N, default 2, number of independent pattern channels; legal range 1..8.
REQ-003 Parameter CW, default 8, width of each per-channel hit counter; legal range 1..16.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 x  input  1  serial data bit.
REQ-007 x_valid  input  1  qualifies x; a bit is accepted only on an edge where x_valid=1.
REQ-008 match  input  N*W  channel i pattern at match[i*W +: W]; MSB is the oldest bit.
REQ-009 care  input  N*W  channel i care mask at care[i*W +: W]; 0 marks a don't-care bit.
REQ-010 overlap  input  1  1 = overlapping detection, 0 = non-overlapping; shared by all channels.
REQ-011 clr_cnt  input  1  synchronous clear of all hit counters.
REQ-012 q  output  W  shift register; q[0] holds the newest bit and q[W-1] the oldest.
REQ-013 z  output  N  per-channel one-cycle hit pulse.
REQ-014 z_any  output  1  OR of z.
REQ-015 filled  output  1  set once W bits have been accepted since reset.
REQ-016 hit_cnt  output  N*CW  channel i saturating hit count at hit_cnt[i*CW +: CW].

Function
REQ-017 On an accepted bit, q SHALL update to {q[W-2:0], x}; otherwise q holds.
REQ-018 A fill counter SHALL count accepted bits, saturate at W, and drive filled=1 from the edge that accepts bit W.
REQ-019 Candidate nq={q[W-2:0],x}; channel i matches when ((nq XOR pattern_i) AND care_i) is all zero.
REQ-020 z[i] SHALL be registered and high for exactly the one cycle after an edge where x_valid=1, the accepted bit is at least bit W, channel i matches, and channel i is armed.
REQ-021 z SHALL be 0 after every edge where x_valid=0, so stall cycles never repeat or extend a pulse.
REQ-022 With overlap=1, every channel SHALL always be armed.
REQ-023 With overlap=0, a hit on channel i SHALL disarm that channel for the next W-1 accepted bits; the channel rearms on the W-th accepted bit, which can itself hit.
REQ-024 Each channel's guard counter SHALL be independent; a hit on one channel does not affect another.
REQ-025 When care_i is all zero, channel i SHALL match on every accepted bit once filled, subject to arming.
REQ-026 hit_cnt[i] SHALL increment on each z[i] assertion edge and saturate at 2^CW-1.
REQ-027 When clr_cnt=1, all counters SHALL be 0 after the edge, including when a hit occurs on the same edge (clear wins).
REQ-028 Changing match, care or overlap mid-stream SHALL take effect on the next accepted bit; guard counts already running are unaffected.

Reset
REQ-029 When rst=1 at an edge, q, the fill counter, filled, z, z_any, all guard counters and hit_cnt SHALL be 0, and all channels SHALL be armed.
REQ-030 rst SHALL take priority over x_valid and clr_cnt; after reset mid-stream, detection SHALL require W fresh accepted bits.

Configuration
REQ-031 Macro SEQDET_MULTI_CNT_EN: when defined, hit counters are implemented as specified in REQ-026 and REQ-027.
REQ-032 When SEQDET_MULTI_CNT_EN is undefined, no counter registers exist, hit_cnt SHALL be constant 0, clr_cnt SHALL be ignored, and all other behaviour is unchanged.

Verification
REQ-033 W=6, N=1, match=110011, care=111111, overlap=1, stream 1100110011 -> z pulses after bits 6 and 10; hit_cnt=2.
REQ-034 Same stream with overlap=0 -> single z pulse after bit 6; a further 110011 starting at bit 11 -> pulse after bit 16.
REQ-035 After reset, match=000000, care=111111, stream of zeros -> filled and first z both after bit 6; no pulse after bits 1-5.
REQ-036 N=2: ch0 match=110000/care=111100, ch1 match=000001/care=000011, stream 110001 -> z=2'b11 and z_any=1 after bit 6.
REQ-037 Stream 110011 with x_valid=0 for 3 cycles between bits 3 and 4 -> q holds during the stall, one z pulse after bit 6, no extra pulses.
REQ-038 CW=2, 5 hits -> hit_cnt=3; clr_cnt on the edge of a 6th hit -> hit_cnt=0; rst after 4 bits of 110011, then bits 11 -> no z and filled=0.
